// File: rtl/arm_pkg.sv
// Shared encodings for the fetch/sequencing stage and the downstream ALU stage.
package arm_pkg;

   // One-hot cycle state; all-zero marks a halted core.
   typedef enum logic [2:0] {
      ST_HALT  = 3'b000,
      ST_FETCH = 3'b001,
      ST_EXEC1 = 3'b010,
      ST_EXEC2 = 3'b100
   } state_e;

   localparam logic [3:0] OPC_LDR  = 4'b1110;
   localparam logic [3:0] OPC_JMP  = 4'b0100;
   localparam logic [3:0] OPC_JZ   = 4'b0101;
   localparam logic [3:0] OPC_HALT = 4'b0111;

   // Jump target: 12-bit immediate zero-extended into the 16-bit address space.
   function automatic logic [15:0] jmp_target(input logic [15:0] ins);
      return {4'b0000, ins[11:0]};
   endfunction

endpackage

// File: rtl/arm_fetch_ctrl_if.sv
// Instruction-memory fetch bus: address/request out, data/valid back.
interface arm_fetch_ctrl_if;
   logic [15:0] imem_addr;
   logic        imem_rd;
   logic [15:0] imem_data;
   logic        imem_valid;

   modport master (output imem_addr, output imem_rd,
                   input  imem_data, input  imem_valid);
   modport slave  (input  imem_addr, input  imem_rd,
                   output imem_data, output imem_valid);
endinterface

// File: rtl/arm_pc_reg.sv
// Program counter: increment on fetch (wraps mod 2^16) or load a jump target.
module arm_pc_reg #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc_en,
   input  logic        ld_en,
   input  logic [15:0] ld_val,
   output logic [15:0] pc
);
   logic [15:0] pc_q, pc_d;

   // Next-pc mux: a jump load wins over increment (they never coincide).
   always_comb begin
      pc_d = pc_q;
      if (ld_en)       pc_d = ld_val;
      else if (inc_en) pc_d = pc_q + 16'd1;
   end

   // PC register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   assign pc = pc_q;
endmodule

// File: rtl/arm_fetch_ctrl.sv
// Fetch and sequencing stage: owns IR, cycle state, zero flag and halt.
module arm_fetch_ctrl
   import arm_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [3:0]  HALT_OPC = OPC_HALT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   arm_fetch_ctrl_if.master        imem,
   input  logic [15:0]             alu_d_out,
   input  logic                    alu_wen,
   output logic [15:0]             inst,
   output logic [2:0]              state,
   output logic [15:0]             pc,
   output logic                    zero_flag,
   output logic                    halted
);
   state_e      state_q;
   logic [15:0] inst_q;
   logic        zero_q;
   logic        halted_q;
   logic [3:0]  opc;
   logic        pc_inc, pc_ld;

   assign opc = inst_q[15:12];

   // PC control: bump on an accepted fetch, load on JMP or a taken JZ.
   always_comb begin
      pc_inc = (state_q == ST_FETCH) && imem.imem_valid;
      pc_ld  = (state_q == ST_EXEC1) &&
               ((opc == OPC_JMP) || ((opc == OPC_JZ) && zero_q));
   end

   arm_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc_en (pc_inc),
      .ld_en  (pc_ld),
      .ld_val (jmp_target(inst_q)),
      .pc     (pc)
   );

   // Sequencer FSM with instruction register, zero flag and halt latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_FETCH;
         inst_q   <= 16'h0000;
         zero_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (imem.imem_valid) begin
                  inst_q  <= imem.imem_data;
                  state_q <= ST_EXEC1;
               end
            end
            ST_EXEC1: begin
               // JZ reads the flag, so it must never overwrite it.
               if (alu_wen && (opc != OPC_JZ))
                  zero_q <= (alu_d_out == 16'h0000);
               if (opc == OPC_LDR)
                  state_q <= ST_EXEC2;
               else if ((opc == OPC_JMP) || (opc == OPC_JZ))
                  state_q <= ST_FETCH;
               else if (opc == HALT_OPC) begin
                  state_q  <= ST_HALT;
                  halted_q <= 1'b1;
               end else
                  state_q <= ST_FETCH;
            end
            ST_EXEC2: state_q <= ST_FETCH;
            ST_HALT:  state_q <= ST_HALT;
            default:  state_q <= ST_FETCH;
         endcase
      end
   end

   assign state          = state_q;
   assign inst           = inst_q;
   assign zero_flag      = zero_q;
   assign halted         = halted_q;
   assign imem.imem_rd   = (state_q == ST_FETCH);
   assign imem.imem_addr = pc;
endmodule

// File: tb/tb_arm_fetch_ctrl.sv
// Self-checking bench: directed vector table, hand sequences, random vs model.
module tb_arm_fetch_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n0, rst_n1;
   logic [15:0] alu0, alu1;
   logic wen0, wen1;
   logic [15:0] inst0, inst1, pc0, pc1;
   logic [2:0] st0, st1;
   logic z0, z1, h0, h1;

   arm_fetch_ctrl_if if0();
   arm_fetch_ctrl_if if1();

   arm_fetch_ctrl dut0 (.clk(clk), .rst_n(rst_n0), .imem(if0), .alu_d_out(alu0),
      .alu_wen(wen0), .inst(inst0), .state(st0), .pc(pc0), .zero_flag(z0), .halted(h0));
   arm_fetch_ctrl #(.RESET_PC(16'hFFFF)) dut1 (.clk(clk), .rst_n(rst_n1), .imem(if1),
      .alu_d_out(alu1), .alu_wen(wen1), .inst(inst1), .state(st1), .pc(pc1),
      .zero_flag(z1), .halted(h1));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        v;
      logic [15:0] d;
      logic        w;
      logic [15:0] a;
      logic [2:0]  st;
      logic [15:0] pc;
      logic [15:0] ins;
      logic        z;
      logic        h;
   } vec_t;

   vec_t vt[18];

   // Model state for random run: phase 0 fetch, 1 exec1, 2 exec2, 3 halted.
   int          m_ph;
   logic [15:0] m_pc, m_inst;
   logic        m_z, m_h;

   task automatic model_step(input logic v, input logic [15:0] d,
                             input logic w, input logic [15:0] a);
      logic [3:0] op;
      op = m_inst[15:12];
      case (m_ph)
         0: if (v) begin m_inst = d; m_pc = m_pc + 16'd1; m_ph = 1; end
         1: begin
            if (w && op != 4'b0101) m_z = (a == 16'h0000);
            if (op == 4'b1110) m_ph = 2;
            else if (op == 4'b0100) begin m_pc = {4'h0, m_inst[11:0]}; m_ph = 0; end
            else if (op == 4'b0101) begin
               if (m_z) m_pc = {4'h0, m_inst[11:0]};
               m_ph = 0;
            end
            else if (op == 4'b0111) begin m_ph = 3; m_h = 1'b1; end
            else m_ph = 0;
         end
         2: m_ph = 0;
         default: m_ph = 3;
      endcase
   endtask

   function automatic logic [2:0] m_state();
      return (m_ph == 3) ? 3'b000 : 3'(1 << m_ph);
   endfunction

   task automatic reset0();
      rst_n0 = 1'b0; if0.imem_valid = 1'b0; if0.imem_data = '0; wen0 = 1'b0; alu0 = '0;
      @(negedge clk); @(negedge clk);
      rst_n0 = 1'b1;
      m_ph = 0; m_pc = 16'h0000; m_inst = 16'h0000; m_z = 1'b0; m_h = 1'b0;
   endtask

   initial begin
      rst_n1 = 1'b0; if1.imem_valid = 1'b0; if1.imem_data = '0; wen1 = 1'b0; alu1 = '0;

      vt[0]  = '{1'b1,16'h8123,1'b0,16'h0000,3'b010,16'h0001,16'h8123,1'b0,1'b0};
      vt[1]  = '{1'b0,16'h0000,1'b1,16'h0000,3'b001,16'h0001,16'h8123,1'b1,1'b0};
      vt[2]  = '{1'b0,16'hE000,1'b0,16'h0000,3'b001,16'h0001,16'h8123,1'b1,1'b0};
      vt[3]  = '{1'b0,16'hE000,1'b0,16'h0000,3'b001,16'h0001,16'h8123,1'b1,1'b0};
      vt[4]  = '{1'b0,16'hE000,1'b0,16'h0000,3'b001,16'h0001,16'h8123,1'b1,1'b0};
      vt[5]  = '{1'b1,16'hE000,1'b0,16'h0000,3'b010,16'h0002,16'hE000,1'b1,1'b0};
      vt[6]  = '{1'b0,16'h0000,1'b0,16'h0000,3'b100,16'h0002,16'hE000,1'b1,1'b0};
      vt[7]  = '{1'b0,16'h0000,1'b1,16'h0005,3'b001,16'h0002,16'hE000,1'b1,1'b0};
      vt[8]  = '{1'b1,16'h5ABC,1'b0,16'h0000,3'b010,16'h0003,16'h5ABC,1'b1,1'b0};
      vt[9]  = '{1'b0,16'h0000,1'b1,16'h0001,3'b001,16'h0ABC,16'h5ABC,1'b1,1'b0};
      vt[10] = '{1'b1,16'h8000,1'b0,16'h0000,3'b010,16'h0ABD,16'h8000,1'b1,1'b0};
      vt[11] = '{1'b0,16'h0000,1'b1,16'h0001,3'b001,16'h0ABD,16'h8000,1'b0,1'b0};
      vt[12] = '{1'b1,16'h5123,1'b0,16'h0000,3'b010,16'h0ABE,16'h5123,1'b0,1'b0};
      vt[13] = '{1'b0,16'h0000,1'b0,16'h0000,3'b001,16'h0ABE,16'h5123,1'b0,1'b0};
      vt[14] = '{1'b1,16'h4FFF,1'b0,16'h0000,3'b010,16'h0ABF,16'h4FFF,1'b0,1'b0};
      vt[15] = '{1'b0,16'h0000,1'b0,16'h0000,3'b001,16'h0FFF,16'h4FFF,1'b0,1'b0};
      vt[16] = '{1'b1,16'h7000,1'b0,16'h0000,3'b010,16'h1000,16'h7000,1'b0,1'b0};
      vt[17] = '{1'b0,16'h0000,1'b0,16'h0000,3'b000,16'h1000,16'h7000,1'b0,1'b1};

      // Reset state.
      reset0();
      rst_n0 = 1'b0;
      #1;
      chk("rst_state", {29'd0, st0}, 32'h1);
      chk("rst_pc", {16'd0, pc0}, 32'h0);
      chk("rst_inst", {16'd0, inst0}, 32'h0);
      chk("rst_zero_halt", {30'd0, z0, h0}, 32'h0);
      chk("rst_rd", {31'd0, if0.imem_rd}, 32'h1);
      @(negedge clk);
      rst_n0 = 1'b1;
      chk("first_addr", {16'd0, if0.imem_addr}, 32'h0);

      // Directed vector table.
      for (int i = 0; i < 18; i++) begin
         if0.imem_valid = vt[i].v; if0.imem_data = vt[i].d;
         wen0 = vt[i].w; alu0 = vt[i].a;
         @(posedge clk); @(negedge clk);
         chk($sformatf("vec%0d_state", i), {29'd0, st0}, {29'd0, vt[i].st});
         chk($sformatf("vec%0d_pc", i), {16'd0, pc0}, {16'd0, vt[i].pc});
         chk($sformatf("vec%0d_inst", i), {16'd0, inst0}, {16'd0, vt[i].ins});
         chk($sformatf("vec%0d_zh", i), {30'd0, z0, h0}, {30'd0, vt[i].z, vt[i].h});
         chk($sformatf("vec%0d_bus", i), {15'd0, if0.imem_rd, if0.imem_addr},
             {15'd0, (vt[i].st == 3'b001), vt[i].pc});
      end

      // Halted core ignores toggling valid.
      for (int i = 0; i < 10; i++) begin
         if0.imem_valid = i[0]; if0.imem_data = 16'h8123;
         @(posedge clk); @(negedge clk);
         chk("halt_hold", {12'd0, if0.imem_rd, h0, st0, pc0}, {12'd0, 1'b0, 1'b1, 3'b000, 16'h1000});
      end

      // Asynchronous reset out of HALTED, checked before the next edge.
      #2 rst_n0 = 1'b0;
      #1;
      chk("async_rst_halt", {13'd0, st0, pc0}, {13'd0, 3'b001, 16'h0000});
      @(negedge clk);
      rst_n0 = 1'b1;

      // Reset in the middle of EXEC2 of a load.
      if0.imem_valid = 1'b1; if0.imem_data = 16'hE000;
      @(posedge clk); @(negedge clk);
      if0.imem_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("ldr_exec2", {29'd0, st0}, 32'h4);
      if0.imem_valid = 1'b1; if0.imem_data = 16'h8001;
      #2 rst_n0 = 1'b0;
      #1;
      chk("rst_exec2", {13'd0, st0, pc0}, {13'd0, 3'b001, 16'h0000});
      chk("rst_exec2_inst", {16'd0, inst0}, 32'h0);
      @(negedge clk);
      rst_n0 = 1'b1;
      chk("refetch_addr", {15'd0, if0.imem_rd, if0.imem_addr}, {15'd0, 1'b1, 16'h0000});
      if0.imem_valid = 1'b0;

      // Wrap with RESET_PC = FFFF.
      @(negedge clk);
      rst_n1 = 1'b1;
      chk("wrap_rst_addr", {16'd0, if1.imem_addr}, 32'hFFFF);
      if1.imem_valid = 1'b1; if1.imem_data = 16'h8000;
      @(posedge clk); @(negedge clk);
      chk("wrap_pc", {13'd0, st1, pc1}, {13'd0, 3'b010, 16'h0000});
      if1.imem_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      if1.imem_valid = 1'b1; if1.imem_data = 16'h4FFF;
      @(posedge clk); @(negedge clk);
      if1.imem_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("wrap_jmp", {13'd0, st1, pc1}, {13'd0, 3'b001, 16'h0FFF});

      // Random stimulus against the instruction-level model.
      reset0();
      for (int c = 0; c < 3000; c++) begin
         logic v, w;
         logic [15:0] d, a;
         int r;
         if (m_h) begin
            reset0();
         end
         r = $urandom_range(0, 99);
         d = 16'($urandom);
         if (r < 15)      d[15:12] = 4'b1110;
         else if (r < 30) d[15:12] = 4'b0100;
         else if (r < 50) d[15:12] = 4'b0101;
         else if (r < 52) d[15:12] = 4'b0111;
         v = ($urandom_range(0, 3) != 0);
         w = $urandom_range(0, 1) == 1;
         a = ($urandom_range(0, 1) == 1) ? 16'h0000 : 16'($urandom);
         if0.imem_valid = v; if0.imem_data = d; wen0 = w; alu0 = a;
         model_step(v, d, w, a);
         @(posedge clk); @(negedge clk);
         chk($sformatf("rand%0d", c),
             {st0, pc0, z0, h0, if0.imem_rd, (if0.imem_addr == pc0)},
             {m_state(), m_pc, m_z, m_h, (m_ph == 0), 1'b1});
         chk($sformatf("rand%0d_inst", c), {16'd0, inst0}, {16'd0, m_inst});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/arm_fetch_ctrl.md
Name: arm_fetch_ctrl

Overview:
Instruction-fetch and sequencing stage for the 16-bit Harvard, non-pipelined core.
- Owns the program counter and the instruction register.
- Fetches from instruction memory through a valid handshake.
- Generates the one-hot cycle state (fetch / exec1 / exec2) and the latched instruction that the downstream ALU stage consumes.
- Resolves jumps and halts, and keeps the zero flag from ALU results.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_OPC, 4'b0111, inst[15:12] opcode that halts the core.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_data  in  16  instruction word returned by instruction memory.
- imem_valid  in  1  imem_data is valid this cycle (memory may stall).
- alu_d_out  in  16  ALU result (d_out of the downstream stage).
- alu_wen  in  1  ALU register-write strobe.
- imem_addr  out  16  fetch address; always equals pc.
- imem_rd  out  1  fetch request; high only in FETCH.
- inst  out  16  latched instruction, held stable through EXEC1/EXEC2.
- state  out  3  one-hot: 3'b001 FETCH, 3'b010 EXEC1, 3'b100 EXEC2, 3'b000 HALTED.
- pc  out  16  current program counter.
- zero_flag  out  1  last ALU result was zero.
- halted  out  1  core stopped.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n), applied immediately regardless of clk.
- Reset values:
  - pc = RESET_PC
  - inst = 16'h0000
  - state = FETCH (3'b001)
  - zero_flag = 0
  - halted = 0
  - imem_rd = 1 (combinational from state)
- FETCH:
  - imem_rd = 1, imem_addr = pc.
  - imem_valid = 0: stay in FETCH; pc and inst unchanged.
  - imem_valid = 1: inst <= imem_data, pc <= pc + 1 (mod 2^16, 16'hFFFF wraps to 16'h0000), go to EXEC1.
- EXEC1: imem_rd = 0; then by opcode inst[15:12]:
  - 4'b1110 (LDR): go to EXEC2.
  - 4'b0100 (JMP): pc <= {4'b0000, inst[11:0]}, go to FETCH.
  - 4'b0101 (JZ): if zero_flag = 1, pc <= {4'b0000, inst[11:0]}; otherwise pc unchanged. Go to FETCH.
  - HALT_OPC: go to HALTED, halted <= 1.
  - Any other opcode: go to FETCH.
- Zero flag: in EXEC1 with alu_wen = 1, zero_flag <= (alu_d_out == 16'h0000). JZ tests the flag value held before this update; a JZ never updates the flag.
- EXEC2: unconditionally go to FETCH. zero_flag is not updated by loads.
- HALTED: state = 3'b000, imem_rd = 0. Held until rst_n is asserted; imem_valid is ignored.
- Latency:
  - Non-load instruction: 2 cycles plus fetch stall cycles.
  - LDR: 3 cycles plus fetch stall cycles.
- Reset mid-fetch: any in-flight imem_valid is discarded; the next fetch comes from RESET_PC.
- state is always exactly one-hot except in HALTED. Illegal state encodings recover to FETCH on the next edge.

Decomposition:
- Shared package arm_pkg holds:
  - state encodings ST_FETCH, ST_EXEC1, ST_EXEC2, ST_HALT;
  - opcode constants OPC_LDR = 4'b1110, OPC_JMP = 4'b0100, OPC_JZ = 4'b0101, OPC_HALT = 4'b0111.
- The ALU stage also uses the state encodings from arm_pkg.
- One natural sub-module: arm_pc_reg, holding the pc register, increment and jump-load mux, and the wrap logic.

Test Plan:
- Reset release with imem_valid = 1 and imem_data = 16'h8123 (add) → state goes 001→010→001; pc goes 0→1; inst = 16'h8123; imem_addr = 0 during the first FETCH.
- imem_valid held low for 3 cycles in FETCH, then imem_data = 16'hE000 (LDR) → state stays 001 for 3 cycles, then 010→100→001; pc increments exactly once.
- JZ after an ALU result of 0: EXEC1 with alu_wen = 1 and alu_d_out = 16'h0000, then fetch 16'h5ABC → zero_flag = 1 and pc = 16'h0ABC. Repeat with alu_d_out = 16'h0001 → pc = previous + 1.
- With RESET_PC = 16'hFFFF, fetch a non-jump instruction → pc wraps to 16'h0000. JMP 16'h4FFF → pc = 16'h0FFF.
- Fetch 16'h7000 → state = 000, halted = 1, imem_rd = 0. Toggling imem_valid for 10 cycles changes nothing. Asserting rst_n low asynchronously → pc = RESET_PC and state = 001 before the next clk edge.
- Assert rst_n low mid-EXEC2 → immediate return to reset values; after release, the first fetch address is RESET_PC.
